m_ifetch: RTL and testbench

Instruction-fetch stage that owns the program counter and issues sequential reads to a synchronous instruction memory. Each returned word is paired with its PC and buffered in a small queue. The queue feeds decode through a valid/ready handshake. A redirect input (branch/jump target from execute) flushes all queued and in-flight fetches and restarts fetch at the target.

---
 rtl/m_cpu_pkg.sv | 19 +
 rtl/m_fetch_fifo.sv | 56 +++++
 rtl/m_ifetch.sv | 81 ++++++++
 tb/tb_m_ifetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_cpu_pkg.sv
// Shared CPU definitions: datapath width, PC step, fetch entry layout and the
// default reset vector used by the pipeline stages.
package m_cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small circular buffer of {pc, ir} entries between fetch and decode.
// Flush beats push; push and pop in the same cycle leave the count unchanged.
module m_fetch_fifo
  import m_cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_cnt;

  always_ff @(posedge w_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples the pre-edge values of the others.
    if (w_rst) begin
      // NOTE: storage is cleared on reset so the head reads as zero afterwards;
      // cheap at this depth, and decode never sees stale words.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head = r_mem[r_rd_ptr];
  assign cnt  = r_cnt;

endmodule

// File: rtl/m_ifetch.sv
// Instruction fetch: owns the PC, issues one read per cycle while buffer credit
// remains, pairs each returned word with its PC and hands it to decode.
module m_ifetch
  import m_cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            w_clk,
  input  logic            w_rst,
  output logic            w_imem_en,
  output logic [XLEN-1:0] w_imem_addr,
  input  logic [XLEN-1:0] w_imem_rdata,
  input  logic            w_redirect,
  input  logic [XLEN-1:0] w_redirect_pc,
  output logic            w_valid,
  input  logic            w_ready,
  output logic [XLEN-1:0] w_pc,
  output logic [XLEN-1:0] w_ir
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;

  logic [CW-1:0]   r_cnt;
  logic [CW:0]     occupancy;
  logic            w_pop;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign w_valid = !w_rst && !w_redirect && (r_cnt != '0);
  assign w_pop   = w_valid && w_ready;

  // Entries that will be held after this cycle's pop; a new request may only
  // go out when its response is guaranteed a free slot next cycle.
  assign occupancy = {1'b0, r_cnt} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_imem_en = !w_rst && !w_redirect && (occupancy < DEPTH_L);

  assign w_imem_addr = w_rst ? RESET_PC : r_pc;
  assign w_pc        = w_rst ? '0 : head.pc;
  assign w_ir        = w_rst ? '0 : head.ir;

  assign push_entry = '{pc: r_inflight_pc, ir: w_imem_rdata};

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (w_redirect) begin
      r_pc       <= align_pc(w_redirect_pc);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_imem_en;
      if (w_imem_en) begin
        r_pc          <= r_pc + PC_INC;
        r_inflight_pc <= r_pc;
      end
    end
  end

  // A redirect flushes the buffer and, through flush priority, drops the
  // response arriving in the same cycle.
  m_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .push       (r_inflight),
    .push_entry (push_entry),
    .pop        (w_pop),
    .flush      (w_redirect),
    .head       (head),
    .cnt        (r_cnt)
  );

endmodule

// File: tb/tb_m_ifetch.sv
// Directed and scoreboard-checked bench for m_ifetch; memory returns addr ^ 32'hA5A50000.
module tb_m_ifetch;
  import m_cpu_pkg::*;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH   = 2;

  logic w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic        w_rst, w_redirect, w_ready;
  logic [31:0] w_redirect_pc;

  logic        imem_en, valid;
  logic [31:0] imem_addr, imem_rdata, pc, ir;

  logic        imem_en2, valid2;
  logic [31:0] imem_addr2, imem_rdata2, pc2, ir2;
  logic        no_redirect = 1'b0;
  logic [31:0] zero_pc     = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_print  = 0;

  m_ifetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_imem_en(imem_en), .w_imem_addr(imem_addr), .w_imem_rdata(imem_rdata),
    .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
    .w_valid(valid), .w_ready(w_ready), .w_pc(pc), .w_ir(ir)
  );

  m_ifetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_imem_en(imem_en2), .w_imem_addr(imem_addr2), .w_imem_rdata(imem_rdata2),
    .w_redirect(no_redirect), .w_redirect_pc(zero_pc),
    .w_valid(valid2), .w_ready(w_ready), .w_pc(pc2), .w_ir(ir2)
  );

  // Synchronous instruction memory models, one-cycle read latency.
  always @(posedge w_clk) begin
    imem_rdata  <= imem_en  ? (imem_addr  ^ K) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_en2 ? (imem_addr2 ^ K) : 32'hDEAD_BEEF;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    w_rst = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
    tick(); tick();
    w_rst = 1'b0;
  endtask

  task automatic test_reset();
    w_rst = 1'b1; w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
    tick(); tick(); #1;
    n_checks++;
    if ({imem_en, valid} !== 2'b00) $display("FAIL reset_ctrl: en,valid=%b expected 00", {imem_en, valid});
    else n_pass++;
    n_checks++;
    if ({pc, ir} !== 64'h0) $display("FAIL reset_head: pc=%h ir=%h expected 0/0", pc, ir);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", imem_addr);
    else n_pass++;
    n_checks++;
    if (imem_addr2 !== WRAP_PC) $display("FAIL reset_addr_wrap: got %h expected %h", imem_addr2, WRAP_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] e_pc;
    w_ready = 1'b1;
    do_reset(); #1;
    n_checks++;
    if ({valid, imem_en, imem_addr} !== {2'b01, 32'h0}) $display("FAIL stream_c0: valid=%b en=%b addr=%h expected 0 1 00000000", valid, imem_en, imem_addr);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({valid, imem_en, imem_addr} !== {2'b01, 32'h4}) $display("FAIL stream_c1: valid=%b en=%b addr=%h expected 0 1 00000004", valid, imem_en, imem_addr);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      e_pc = 32'(4 * k);
      n_checks++;
      if ({valid, pc, ir} !== {1'b1, e_pc, e_pc ^ K}) $display("FAIL stream_head%0d: valid=%b pc=%h ir=%h expected 1 %h %h", k, valid, pc, ir, e_pc, e_pc ^ K);
      else n_pass++;
      n_checks++;
      if ({imem_en, imem_addr} !== {1'b1, e_pc + 32'd8}) $display("FAIL stream_req%0d: en=%b addr=%h expected 1 %h", k, imem_en, imem_addr, e_pc + 32'd8);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    w_ready = 1'b0;
    do_reset(); #1;
    tick(); #1;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL stall_c1_valid: got %b expected 0", valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      n_checks++;
      if ({valid, pc, ir, imem_en} !== {1'b1, 32'h0, K, 1'b0}) $display("FAIL stall_hold%0d: valid=%b pc=%h ir=%h en=%b expected 1 00000000 %h 0", i, valid, pc, ir, imem_en, K);
      else n_pass++;
    end
    tick(); w_ready = 1'b1; #1;
    n_checks++;
    if ({pc, ir, imem_en, imem_addr} !== {32'h0, K, 1'b1, 32'h8}) $display("FAIL stall_rel0: pc=%h ir=%h en=%b addr=%h expected 00000000 %h 1 00000008", pc, ir, imem_en, imem_addr, K);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({valid, pc, ir, imem_addr} !== {1'b1, 32'h4, 32'hA5A5_0004, 32'hC}) $display("FAIL stall_rel1: valid=%b pc=%h ir=%h addr=%h expected 1 00000004 a5a50004 0000000c", valid, pc, ir, imem_addr);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({valid, pc, ir} !== {1'b1, 32'h8, 32'hA5A5_0008}) $display("FAIL stall_rel2: valid=%b pc=%h ir=%h expected 1 00000008 a5a50008", valid, pc, ir);
    else n_pass++;
  endtask

  task automatic test_redirect();
    w_ready = 1'b1;
    do_reset(); #1;
    tick(); tick(); tick();
    tick(); w_ready = 1'b0; #1;
    n_checks++;
    if ({valid, pc, imem_en} !== {1'b1, 32'h8, 1'b0}) $display("FAIL redir_pre: valid=%b pc=%h en=%b expected 1 00000008 0", valid, pc, imem_en);
    else n_pass++;
    w_redirect = 1'b1; w_redirect_pc = 32'h0000_0103; #1;
    n_checks++;
    if ({valid, imem_en} !== 2'b00) $display("FAIL redir_cycle: valid=%b en=%b expected 0 0", valid, imem_en);
    else n_pass++;
    tick(); w_redirect = 1'b0; w_ready = 1'b1; #1;
    n_checks++;
    if ({valid, imem_en, imem_addr} !== {2'b01, 32'h100}) $display("FAIL redir_req: valid=%b en=%b addr=%h expected 0 1 00000100", valid, imem_en, imem_addr);
    else n_pass++;
    for (int i = 0; i < 6 && valid !== 1'b1; i++) begin tick(); #1; end
    n_checks++;
    if ({valid, pc, ir} !== {1'b1, 32'h100, 32'hA5A5_0100}) $display("FAIL redir_first: valid=%b pc=%h ir=%h expected 1 00000100 a5a50100", valid, pc, ir);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({valid, pc, ir} !== {1'b1, 32'h104, 32'hA5A5_0104}) $display("FAIL redir_second: valid=%b pc=%h ir=%h expected 1 00000104 a5a50104", valid, pc, ir);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] e_pc[4];
    logic [31:0] e_ir[4];
    e_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    e_ir = '{32'h5A5A_FFF8, 32'h5A5A_FFFC, 32'hA5A5_0000, 32'hA5A5_0004};
    w_ready = 1'b1;
    do_reset(); #1;
    n_checks++;
    if ({imem_en2, imem_addr2} !== {1'b1, WRAP_PC}) $display("FAIL wrap_req0: en=%b addr=%h expected 1 %h", imem_en2, imem_addr2, WRAP_PC);
    else n_pass++;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_checks++;
      if ({valid2, pc2, ir2} !== {1'b1, e_pc[k], e_ir[k]}) $display("FAIL wrap_head%0d: valid=%b pc=%h ir=%h expected 1 %h %h", k, valid2, pc2, ir2, e_pc[k], e_ir[k]);
      else n_pass++;
    end
  endtask

  task automatic test_midreset();
    w_ready = 1'b1;
    do_reset(); #1;
    tick(); tick(); tick();
    tick(); w_ready = 1'b0; #1;
    w_rst = 1'b1; #1;
    n_checks++;
    if ({imem_en, valid, pc, ir, imem_addr} !== {2'b00, 64'h0, 32'h0}) $display("FAIL midrst_during: en=%b valid=%b pc=%h ir=%h addr=%h expected all 0", imem_en, valid, pc, ir, imem_addr);
    else n_pass++;
    tick(); w_rst = 1'b0; w_ready = 1'b1; #1;
    n_checks++;
    if ({valid, imem_en, imem_addr} !== {2'b01, 32'h0}) $display("FAIL midrst_after: valid=%b en=%b addr=%h expected 0 1 00000000", valid, imem_en, imem_addr);
    else n_pass++;
    for (int i = 0; i < 6 && valid !== 1'b1; i++) begin tick(); #1; end
    n_checks++;
    if ({valid, pc, ir} !== {1'b1, 32'h0, K}) $display("FAIL midrst_first: valid=%b pc=%h ir=%h expected 1 00000000 %h", valid, pc, ir, K);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({valid, pc, ir} !== {1'b1, 32'h4, 32'hA5A5_0004}) $display("FAIL midrst_second: valid=%b pc=%h ir=%h expected 1 00000004 a5a50004", valid, pc, ir);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_inf_pc;
    logic        m_inf, e_valid, e_pop, e_en;
    logic [63:0] q[$];
    int          occ, dut_out, max_out;
    m_pc = 32'h0; m_inf = 1'b0; m_inf_pc = '0; dut_out = 0; max_out = 0;
    w_ready = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc > 0) tick();
      w_ready       = ($urandom_range(0, 3) != 0);
      w_redirect    = ($urandom_range(0, 63) == 0);
      w_redirect_pc = $urandom;
      #1;
      e_valid = (q.size() != 0) && !w_redirect;
      e_pop   = e_valid && w_ready;
      occ     = q.size() + int'(m_inf) - int'(e_pop);
      e_en    = !w_redirect && (occ < DEPTH);
      n_checks++;
      if ({valid, imem_en, imem_addr} !== {e_valid, e_en, m_pc}) begin
        if (n_print < 20) $display("FAIL rand_ctrl@%0d: valid=%b en=%b addr=%h expected %b %b %h", cyc, valid, imem_en, imem_addr, e_valid, e_en, m_pc);
        n_print++;
      end else n_pass++;
      if (e_valid) begin
        n_checks++;
        if ({pc, ir} !== q[0]) begin
          if (n_print < 20) $display("FAIL rand_head@%0d: pc=%h ir=%h expected %h %h", cyc, pc, ir, q[0][63:32], q[0][31:0]);
          n_print++;
        end else n_pass++;
      end
      // Outstanding words derived from the DUT's own handshakes.
      if (w_redirect) dut_out = 0;
      else dut_out = dut_out + int'(imem_en) - int'(valid && w_ready);
      if (dut_out > max_out) max_out = dut_out;
      if (w_redirect) begin
        q.delete();
        m_inf = 1'b0;
        m_pc  = {w_redirect_pc[31:2], 2'b00};
      end else begin
        if (e_pop) void'(q.pop_front());
        if (m_inf) q.push_back({m_inf_pc, m_inf_pc ^ K});
        m_inf = e_en;
        if (e_en) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
    w_redirect = 1'b0;
    n_checks++;
    if (max_out > DEPTH) $display("FAIL rand_overfill: peak outstanding=%0d allowed %0d", max_out, DEPTH);
    else n_pass++;
  endtask

  initial begin
    w_rst = 1'b1; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
